// File: rtl/md_pkg.sv
// Shared encodings and default latencies for the multiply/divide scheduler.
// Used by md_sched and md_alu.
package md_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } md_state_e;

  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;

endpackage

// File: rtl/md_alu.sv
// Combinational MIPS mult/div datapath: {hi,lo} result plus divide-by-zero flag.
// Division works on magnitudes so INT_MIN / -1 wraps without overflow traps.
module md_alu
  import md_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] res,
  output logic        dz
);

  logic        sgn;
  logic        na;
  logic        nb;
  logic [63:0] ea;
  logic [63:0] eb;
  logic [63:0] prod;
  logic [31:0] ua;
  logic [31:0] ub;
  logic [31:0] ub_s;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] q;
  logic [31:0] r;

  assign sgn  = (op == OP_MULT) || (op == OP_DIV);
  assign na   = sgn & a[31];
  assign nb   = sgn & b[31];

  assign ea   = {{32{na}}, a};
  assign eb   = {{32{nb}}, b};
  assign prod = ea * eb;

  assign ua   = na ? -a : a;
  assign ub   = nb ? -b : b;
  assign ub_s = (ub == 32'd0) ? 32'd1 : ub;
  assign uq   = ua / ub_s;
  assign ur   = ua % ub_s;
  // quotient truncates toward zero; remainder follows dividend sign
  assign q    = (na ^ nb) ? -uq : uq;
  assign r    = na ? -ur : ur;

  assign dz   = op[1] && (b == 32'd0);
  assign res  = op[1] ? {r, q} : prod;

endmodule

// File: rtl/md_sched.sv
// HI/LO multiply-divide scheduler: IDLE/RUN FSM with fixed-latency countdown.
// Optional MD_SCHED_FLUSH_EN adds a flush input that aborts in-flight ops.
module md_sched
  import md_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
`ifdef MD_SCHED_FLUSH_EN
  input  logic        flush,
`endif
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  md_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        busy_q;
  logic [63:0] res;
  logic        dz;
  logic        flush_w;

`ifdef MD_SCHED_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  md_alu u_alu (
    .op  (op_q),
    .a   (a_q),
    .b   (b_q),
    .res (res),
    .dz  (dz)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start && !flush_w) begin
            op_q    <= op;
            a_q     <= a;
            b_q     <= b;
            cnt_q   <= op[1] ? CW'(DIV_LAT) : CW'(MULT_LAT);
            state_q <= S_RUN;
            busy_q  <= 1'b1;
          end else begin
            if (mthi) hi_q <= wdata;
            if (mtlo) lo_q <= wdata;
          end
        end
        S_RUN: begin
          if (flush_w) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q == CW'(1)) begin
            if (!dz) begin
              hi_q <= res[63:32];
              lo_q <= res[31:0];
            end
            cnt_q   <= '0;
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_sched.sv
// Scoreboard bench for md_sched: directed MIPS cases plus random ops.
// Reference model uses 64-bit integer arithmetic on the architectural rules.
module tb_md_sched;

  localparam int MLAT = 5;
  localparam int DLAT = 10;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op    = 2'b00;
  logic [31:0] a     = '0;
  logic [31:0] b     = '0;
  logic        mthi  = 1'b0;
  logic        mtlo  = 1'b0;
  logic [31:0] wdata = '0;
`ifdef MD_SCHED_FLUSH_EN
  logic        flush = 1'b0;
`endif
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  always #5 clk = ~clk;

  md_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .wdata (wdata),
`ifdef MD_SCHED_FLUSH_EN
    .flush (flush),
`endif
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] m_hi  = '0;
  logic [31:0] m_lo  = '0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Architectural result of one op applied to the model HI/LO
  task automatic model(input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y);
    longint sx, sy, p, q, r;
    logic [63:0] u;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: begin
        p = sx * sy;
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      2'b01: begin
        u = {32'd0, x} * {32'd0, y};
        m_hi = u[63:32];
        m_lo = u[31:0];
      end
      2'b10: if (y != 0) begin
        q = sx / sy;
        r = sx % sy;
        m_lo = q[31:0];
        m_hi = r[31:0];
      end
      default: if (y != 0) begin
        m_lo = x / y;
        m_hi = x % y;
      end
    endcase
  endtask

  // Monitor: on each busy fall, pop and compare HI/LO and busy length
  int   bcnt  = 0;
  logic bprev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      bcnt  = 0;
      bprev = 1'b0;
    end else begin
      if (busy) begin
        bcnt++;
      end else if (bprev) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got completion expected none");
        end else begin
          e = exp_q.pop_front();
          chk({e.name, "_hi"}, hi, e.hi);
          chk({e.name, "_lo"}, lo, e.lo);
          chk({e.name, "_lat"}, bcnt, e.lat);
        end
        bcnt = 0;
      end
      bprev = busy;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle;
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: busy=%0b expected 0", busy);
    end
  endtask

  task automatic push_exp(input logic [1:0] o, input string name);
    exp_t e;
    e.hi   = m_hi;
    e.lo   = m_lo;
    e.lat  = o[1] ? DLAT : MLAT;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic do_op(input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input string name);
    wait_idle();
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    model(o, x, y);
    push_exp(o, name);
    tick();
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
  endtask

  initial begin
    logic [31:0] w;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    do_op(2'b00, 32'hFFFF_FFFF, 32'd2, "mult_m1x2");
    do_op(2'b01, 32'hFFFF_FFFF, 32'd2, "multu_m1x2");
    do_op(2'b10, -32'sd7, 32'd2, "div_m7d2");
    do_op(2'b11, 32'd7, 32'd2, "divu_7d2");
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
    do_op(2'b10, 32'd7, 32'hFFFF_FFFE, "div_7dm2");

    wait_idle();
    mthi  = 1'b1;
    wdata = 32'h1234;
    tick();
    mthi  = 1'b0;
    m_hi  = 32'h1234;
    chk("mthi_idle", hi, m_hi);

    wait_idle();
    mtlo  = 1'b1;
    wdata = 32'hAA;
    tick();
    mtlo  = 1'b0;
    m_lo  = 32'hAA;
    chk("mtlo_idle", lo, m_lo);
    do_op(2'b11, 32'd99, 32'd0, "divu_by0");

    do_op(2'b01, 32'd300, 32'd7, "mtlo_in_run");
    tick();
    mtlo  = 1'b1;
    mthi  = 1'b1;
    wdata = 32'hDEAD;
    tick();
    mtlo  = 1'b0;
    mthi  = 1'b0;

    do_op(2'b00, 32'd11, 32'd13, "start_in_run");
    tick();
    start = 1'b1;
    op    = 2'b11;
    a     = 32'd100;
    b     = 32'd3;
    tick();
    start = 1'b0;

    wait_idle();
    start = 1'b1;
    op    = 2'b10;
    a     = 32'd5;
    b     = 32'd0;
    mthi  = 1'b1;
    wdata = 32'h5555;
    push_exp(2'b10, "start_beats_mthi");
    tick();
    start = 1'b0;
    mthi  = 1'b0;

`ifdef MD_SCHED_FLUSH_EN
    wait_idle();
    w = m_hi;
    ra = m_lo;
    do_op(2'b10, 32'd50, 32'd7, "flushed_div");
    m_hi = w;
    m_lo = ra;
    exp_q[$].hi  = w;
    exp_q[$].lo  = ra;
    exp_q[$].lat = 2;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    do_op(2'b11, 32'd50, 32'd7, "after_flush");
`endif

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
      do_op(ro, ra, rb, $sformatf("rnd%0d", i));
      if ($urandom_range(0, 2) == 0) begin
        wait_idle();
        w     = $urandom;
        wdata = w;
        mthi  = 1'($urandom_range(0, 1));
        mtlo  = 1'($urandom_range(0, 1));
        if (mthi) m_hi = w;
        if (mtlo) m_lo = w;
        tick();
        mthi = 1'b0;
        mtlo = 1'b0;
        chk($sformatf("rnd_mt_hi%0d", i), hi, m_hi);
        chk($sformatf("rnd_mt_lo%0d", i), lo, m_lo);
      end
    end

    do_op(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, "pre_reset");
    wait_idle();
    do_op(2'b01, 32'hFFFF_0000, 32'h0000_FFFF, "reset_victim");
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    m_hi = '0;
    m_lo = '0;
    chk("midrun_rst_busy", busy, 0);
    chk("midrun_rst_hi", hi, 0);
    chk("midrun_rst_lo", lo, 0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (8) tick();
    chk("post_rst_hi", hi, 0);
    chk("post_rst_lo", lo, 0);
    chk("post_rst_busy", busy, 0);

    do_op(2'b11, 32'd1000, 32'd7, "after_reset");
    wait_idle();
    tick();
    tick();
    chk("final_hi", hi, m_hi);
    chk("final_lo", lo, m_lo);
    chk("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
